// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states and queue entry layout.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] pc;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO with registered head/valid; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  entry_t     i_din,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic [1:0] o_occ,
  output logic [1:0] o_occ_nxt_c,
  output logic       o_valid,
  output entry_t     o_head
);

  logic [1:0] r_occ;
  logic [1:0] w_occ_nxt;
  logic       r_valid;
  logic       w_pop;
  entry_t     r_head;
  entry_t     r_tail;

  assign w_pop = i_pop && (r_occ != 2'd0);

  always_comb begin
    w_occ_nxt = r_occ;
    if (i_flush) begin
      w_occ_nxt = 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10:   w_occ_nxt = r_occ + 2'd1;
        2'b01:   w_occ_nxt = r_occ - 2'd1;
        default: w_occ_nxt = r_occ;
      endcase
    end
  end

  // Head/tail shift: the head register always holds the oldest entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_occ   <= 2'd0;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != 2'd0);
      if (!i_flush) begin
        if (w_pop) begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_din;
          end else if (i_push) begin
            r_head <= i_din;
          end
        end else if (i_push) begin
          if (r_occ == 2'd0) r_head <= i_din;
          else               r_tail <= i_din;
        end
      end
    end
  end

  assign o_occ       = r_occ;
  assign o_occ_nxt_c = w_occ_nxt;
  assign o_valid     = r_valid;
  assign o_head      = r_head;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, tracks the one-cycle memory latency with a credit
// rule, and hands buffered instructions to decode over valid/ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(511)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  output logic [ADDR_W-1:0] pccounter,
  input  logic [DATA_W-1:0] saidaInstrucao,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_inflight;
  logic              w_inflight_nxt;
  logic [ADDR_W-1:0] r_tag;
  logic [ADDR_W-1:0] w_tag_nxt;
  logic              r_busy;
  logic              r_done;

  logic              w_active;
  logic              w_redirect;
  logic              w_pop;
  logic              w_push;
  logic              w_credit_ok;
  logic              w_issue;
  logic [1:0]        w_occ;
  logic [1:0]        w_occ_nxt;
  logic              w_q_valid;
  entry_t            w_din;
  entry_t            w_head;

  assign w_active   = (r_state == RUN) || (r_state == DRAIN);
  assign w_redirect = redirect_valid && w_active;
  assign w_pop      = w_q_valid && instr_ready;
  // A redirect drops the in-flight tag, so the returning word is never queued.
  assign w_push     = r_inflight && !w_redirect;

  // Credits: queued + in flight, less what leaves this cycle, must stay below two.
  assign w_credit_ok = (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_issue     = (r_state == RUN) && !halt && !redirect_valid && w_credit_ok;

  assign w_din.data = DEF_DATA_W'(saidaInstrucao);
  assign w_din.pc   = DEF_ADDR_W'(r_tag);

  fetch_queue u_queue (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_din       (w_din),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_occ       (w_occ),
    .o_occ_nxt_c (w_occ_nxt),
    .o_valid     (w_q_valid),
    .o_head      (w_head)
  );

  // Next-state, PC and in-flight tracking.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inflight_nxt = 1'b0;
    w_tag_nxt      = r_tag;

    if (w_issue) begin
      w_inflight_nxt = 1'b1;
      w_tag_nxt      = r_pc;
    end

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = RESET_PC;
        end
      end
      RUN: begin
        if (w_issue) begin
          if (r_pc == PC_LAST) w_state_nxt = DRAIN;
          else                 w_pc_nxt    = r_pc + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if ((w_occ_nxt == 2'd0) && !w_inflight_nxt) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_redirect) begin
      w_state_nxt    = RUN;
      w_pc_nxt       = redirect_pc;
      w_inflight_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inflight <= w_inflight_nxt;
      r_tag      <= w_tag_nxt;
      r_busy     <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done     <= (w_state_nxt == DONE);
    end
  end

  assign pccounter   = r_pc;
  assign instr_valid = w_q_valid;
  assign instr_data  = DATA_W'(w_head.data);
  assign instr_pc    = ADDR_W'(w_head.pc);
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
